// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
// Shared definitions for the median quickselect sequencer: window sizing,
// first-pass pivot, pass limit, FSM state encoding, replay-partition codes
// and the floor-midpoint helper used to pick the next pivot.
// ---------------------------------------------------------------------------
package median_pkg;

  localparam int BUFF_SIZE     = 32;
  localparam int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1;
  localparam logic [7:0] INIT_PIVOT = 8'd128;
  localparam int MAX_PASS      = 10;

  typedef logic [BUFF_SIZE_BIT-1:0] size_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FILL   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PART_ALL    = 2'b00,
    PART_LOWER  = 2'b01,
    PART_LARGER = 2'b10
  } part_t;

  // Floor of (a+b)/2 using a 9-bit sum so 255+255 does not wrap.
  function automatic logic [7:0] floor_mid(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8:1];
  endfunction

endpackage

// File: rtl/median_select_ctrl_if.sv
// ---------------------------------------------------------------------------
// median_select_ctrl_if
// Bundles the three signal groups around the sequencer:
//   request/result : start, in_buff_size, in_median_pos, busy,
//                    result, result_err, result_valid, result_ready
//   datapath status: fill_done, lower/equal/larger_size, min/max extrema
//   datapath ctrl  : pivot, buff_size, send_req, sending, part_sel
// modport master : the sequencer's view (it drives the datapath controls)
// modport slave  : the surrounding source/datapath view
// ---------------------------------------------------------------------------
interface median_select_ctrl_if;
  import median_pkg::*;

  logic        start;
  size_t       in_buff_size;
  size_t       in_median_pos;
  logic        busy;

  logic        fill_done;
  size_t       lower_size;
  size_t       equal_size;
  size_t       larger_size;
  logic [7:0]  min_lower;
  logic [7:0]  max_lower;
  logic [7:0]  min_larger;
  logic [7:0]  max_larger;

  logic [7:0]  pivot;
  size_t       buff_size;
  logic        send_req;
  logic        sending;
  logic [1:0]  part_sel;

  logic [7:0]  result;
  logic        result_err;
  logic        result_valid;
  logic        result_ready;

  modport master (
    input  start, in_buff_size, in_median_pos,
    input  fill_done, lower_size, equal_size, larger_size,
    input  min_lower, max_lower, min_larger, max_larger,
    input  result_ready,
    output busy, pivot, buff_size, send_req, sending, part_sel,
    output result, result_err, result_valid
  );

  modport slave (
    output start, in_buff_size, in_median_pos,
    output fill_done, lower_size, equal_size, larger_size,
    output min_lower, max_lower, min_larger, max_larger,
    output result_ready,
    input  busy, pivot, buff_size, send_req, sending, part_sel,
    input  result, result_err, result_valid
  );

endinterface

// File: rtl/median_pivot_calc.sv
// ---------------------------------------------------------------------------
// median_pivot_calc
// Combinational decision for one finished partition pass.
// Inputs : k (rank inside the current set), partition sizes and extrema,
//          current pivot, limit_hit (this pass is the last one allowed).
// Outputs: done/err/result when the search ends, otherwise the next pivot,
//          size, rank and the partition upstream must replay.
// ---------------------------------------------------------------------------
module median_pivot_calc
  import median_pkg::*;
(
  input  size_t       k,
  input  size_t       lower_size,
  input  size_t       equal_size,
  input  size_t       larger_size,
  input  logic [7:0]  min_lower,
  input  logic [7:0]  max_lower,
  input  logic [7:0]  min_larger,
  input  logic [7:0]  max_larger,
  input  logic [7:0]  pivot,
  input  logic        limit_hit,
  output logic        done,
  output logic        err,
  output logic [7:0]  result,
  output logic [7:0]  next_pivot,
  output size_t       next_size,
  output size_t       next_k,
  output part_t       next_part
);

  // One bit wider so lower+equal never wraps at a full window.
  logic [BUFF_SIZE_BIT:0] le_sum;
  logic                   resolved;

  always_comb begin
    le_sum     = {1'b0, lower_size} + {1'b0, equal_size};
    resolved   = 1'b0;
    result     = pivot;
    next_pivot = pivot;
    next_size  = lower_size;
    next_k     = k;
    next_part  = PART_ALL;

    if (k < lower_size) begin
      if (lower_size == size_t'(1) || min_lower == max_lower) begin
        resolved = 1'b1;
        result   = min_lower;
      end else begin
        next_size  = lower_size;
        next_pivot = floor_mid(min_lower, max_lower);
        next_part  = PART_LOWER;
      end
    end else if ({1'b0, k} < le_sum) begin
      resolved = 1'b1;
      result   = pivot;
    end else begin
      next_k = k - lower_size - equal_size;
      if (larger_size == size_t'(1) || min_larger == max_larger) begin
        resolved = 1'b1;
        result   = min_larger;
      end else begin
        next_size  = larger_size;
        next_pivot = floor_mid(min_larger, max_larger);
        next_part  = PART_LARGER;
      end
    end

    // Out of passes: report the pivot of the pass that failed to resolve.
    err = !resolved && limit_hit;
    if (err) begin
      result = pivot;
    end
    done = resolved || err;
  end

endmodule

// File: rtl/median_select_ctrl.sv
// ---------------------------------------------------------------------------
// median_select_ctrl
// Iterative quickselect sequencer for the fill_buffers partition datapath.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - median_select_ctrl_if.master: start/size/rank request, busy,
//          datapath controls (pivot, buff_size, send_req, sending, part_sel),
//          datapath status (fill_done, partition sizes and extrema) and the
//          result/result_err/result_valid/result_ready handshake.
// Each pass: CLEAR (clear pulse), FILL (wait fill_done), DECIDE (pick the
// partition holding rank k or finish). One median is returned per start.
// ---------------------------------------------------------------------------
module median_select_ctrl #(
  parameter logic [7:0] INIT_PIVOT = median_pkg::INIT_PIVOT,
  parameter int         MAX_PASS   = median_pkg::MAX_PASS
) (
  input logic                clk,
  input logic                rst,
  median_select_ctrl_if.master bus
);
  import median_pkg::*;

  localparam int PASS_W = $clog2(MAX_PASS + 1);
  typedef logic [PASS_W-1:0] pass_t;

  state_t      state_reg,     state_next;
  logic [7:0]  pivot_reg,     pivot_next;
  size_t       buff_size_reg, buff_size_next;
  part_t       part_reg,      part_next;
  logic [7:0]  result_reg,    result_next;
  logic        err_reg,       err_next;
  size_t       k_reg,         k_next;
  pass_t       pass_reg,      pass_next;

  pass_t       pass_inc;
  size_t       size_m1;
  logic        calc_done;
  logic        calc_err;
  logic [7:0]  calc_result;
  logic [7:0]  calc_pivot;
  size_t       calc_size;
  size_t       calc_k;
  part_t       calc_part;

  assign pass_inc = pass_reg + pass_t'(1);
  assign size_m1  = bus.in_buff_size - size_t'(1);

  median_pivot_calc u_calc (
    .k           (k_reg),
    .lower_size  (bus.lower_size),
    .equal_size  (bus.equal_size),
    .larger_size (bus.larger_size),
    .min_lower   (bus.min_lower),
    .max_lower   (bus.max_lower),
    .min_larger  (bus.min_larger),
    .max_larger  (bus.max_larger),
    .pivot       (pivot_reg),
    .limit_hit   (pass_inc >= pass_t'(MAX_PASS)),
    .done        (calc_done),
    .err         (calc_err),
    .result      (calc_result),
    .next_pivot  (calc_pivot),
    .next_size   (calc_size),
    .next_k      (calc_k),
    .next_part   (calc_part)
  );

  // State and datapath-control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pivot_reg     <= INIT_PIVOT;
      buff_size_reg <= '0;
      part_reg      <= PART_ALL;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      k_reg         <= '0;
      pass_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      pivot_reg     <= pivot_next;
      buff_size_reg <= buff_size_next;
      part_reg      <= part_next;
      result_reg    <= result_next;
      err_reg       <= err_next;
      k_reg         <= k_next;
      pass_reg      <= pass_next;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_next     = state_reg;
    pivot_next     = pivot_reg;
    buff_size_next = buff_size_reg;
    part_next      = part_reg;
    result_next    = result_reg;
    err_next       = err_reg;
    k_next         = k_reg;
    pass_next      = pass_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.in_buff_size == '0) begin
            result_next = '0;
            err_next    = 1'b1;
            state_next  = ST_DONE;
          end else begin
            // Clamp the rank into the window so a pass always resolves.
            k_next         = (bus.in_median_pos > size_m1) ? size_m1 : bus.in_median_pos;
            pivot_next     = INIT_PIVOT;
            buff_size_next = bus.in_buff_size;
            part_next      = PART_ALL;
            pass_next      = '0;
            err_next       = 1'b0;
            state_next     = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        state_next = ST_FILL;
      end
      ST_FILL: begin
        if (bus.fill_done) begin
          state_next = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        pass_next = pass_inc;
        if (calc_done) begin
          result_next = calc_result;
          err_next    = calc_err;
          state_next  = ST_DONE;
        end else begin
          pivot_next     = calc_pivot;
          buff_size_next = calc_size;
          k_next         = calc_k;
          part_next      = calc_part;
          state_next     = ST_CLEAR;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          err_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; all zero in IDLE so reset values fall out.
  always_comb begin
    bus.busy         = (state_reg != ST_IDLE);
    bus.send_req     = (state_reg == ST_CLEAR);
    // Hold the datapath count from the decision until the handshake.
    bus.sending      = (state_reg == ST_DECIDE) || (state_reg == ST_DONE);
    bus.result_valid = (state_reg == ST_DONE);
  end

  assign bus.pivot      = pivot_reg;
  assign bus.buff_size  = buff_size_reg;
  assign bus.part_sel   = part_reg;
  assign bus.result     = result_reg;
  assign bus.result_err = err_reg;

endmodule

// File: tb/tb_median_select_ctrl.sv
module tb_median_select_ctrl;
  import median_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_select_ctrl_if bus();

  median_select_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] win [0:31];
  int cur_s     = 0;
  int dp_set[$];
  int dp_pivot  = 0;
  int dp_count  = 0;
  int stall_at  = 0;
  int sends     = 0;

  int exp_piv[$];
  int exp_size[$];
  int exp_part[$];
  int exp_res   = 0;
  int exp_err   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference quickselect: partitions the actual set of values each pass,
  // recording the pivot/size/partition every pass must present.
  task automatic model_run(input int s, input int pos, output int res, output int err, output int npass);
    int q[$];
    int lo[$];
    int eq[$];
    int hi[$];
    int k;
    int piv;
    int part;
    int cur_piv;
    exp_piv.delete();
    exp_size.delete();
    exp_part.delete();
    npass = 0;
    err = 0;
    res = 0;
    if (s == 0) begin
      err = 1;
      return;
    end
    k = (pos > s - 1) ? s - 1 : pos;
    for (int i = 0; i < s; i++) q.push_back(int'(win[i]));
    piv = 128;
    part = 0;
    for (int p = 0; p < 64; p++) begin
      exp_piv.push_back(piv);
      exp_size.push_back(q.size());
      exp_part.push_back(part);
      npass++;
      cur_piv = piv;
      lo.delete(); eq.delete(); hi.delete();
      foreach (q[i]) begin
        if (q[i] < piv) lo.push_back(q[i]);
        else if (q[i] == piv) eq.push_back(q[i]);
        else hi.push_back(q[i]);
      end
      if (k < lo.size()) begin
        lo.sort();
        if (lo.size() == 1 || lo[0] == lo[$]) begin res = lo[0]; return; end
        q = lo; piv = (lo[0] + lo[$]) / 2; part = 1;
      end else if (k < lo.size() + eq.size()) begin
        res = piv;
        return;
      end else begin
        k -= lo.size() + eq.size();
        hi.sort();
        if (hi.size() == 1 || hi[0] == hi[$]) begin res = hi[0]; return; end
        q = hi; piv = (hi[0] + hi[$]) / 2; part = 2;
      end
      if (npass >= MAX_PASS) begin
        err = 1;
        res = cur_piv;
        return;
      end
    end
  endtask

  function automatic int sorted_rank(input int s, input int pos);
    int q[$];
    int k;
    k = (pos > s - 1) ? s - 1 : pos;
    for (int i = 0; i < s; i++) q.push_back(int'(win[i]));
    q.sort();
    return q[k];
  endfunction

  // Datapath stand-in: on each clear pulse, form the replayed set from
  // part_sel, partition it around the presented pivot and report fill_done
  // after a random delay.
  initial begin : datapath_model
    int dp_wait;
    int lo_n, eq_n, hi_n;
    int mnl, mxl, mng, mxg;
    int nq[$];
    dp_wait = -1;
    bus.fill_done = 1'b0;
    bus.lower_size = '0; bus.equal_size = '0; bus.larger_size = '0;
    bus.min_lower = '0; bus.max_lower = '0; bus.min_larger = '0; bus.max_larger = '0;
    forever begin
      @(negedge clk);
      bus.fill_done = 1'b0;
      if (rst) begin
        dp_wait = -1;
      end else if (bus.send_req) begin
        if (bus.part_sel == 2'b00) begin
          dp_set.delete();
          for (int i = 0; i < cur_s; i++) dp_set.push_back(int'(win[i]));
        end else begin
          nq.delete();
          foreach (dp_set[i])
            if ((bus.part_sel == 2'b01 && dp_set[i] < dp_pivot) ||
                (bus.part_sel == 2'b10 && dp_set[i] > dp_pivot))
              nq.push_back(dp_set[i]);
          dp_set = nq;
        end
        dp_pivot = int'(bus.pivot);
        lo_n = 0; eq_n = 0; hi_n = 0;
        mnl = 255; mxl = 0; mng = 255; mxg = 0;
        foreach (dp_set[i]) begin
          if (dp_set[i] < dp_pivot) begin
            lo_n++;
            if (dp_set[i] < mnl) mnl = dp_set[i];
            if (dp_set[i] > mxl) mxl = dp_set[i];
          end else if (dp_set[i] == dp_pivot) begin
            eq_n++;
          end else begin
            hi_n++;
            if (dp_set[i] < mng) mng = dp_set[i];
            if (dp_set[i] > mxg) mxg = dp_set[i];
          end
        end
        if (lo_n == 0) begin mnl = 0; mxl = 0; end
        if (hi_n == 0) begin mng = 0; mxg = 0; end
        bus.lower_size  = size_t'(lo_n);
        bus.equal_size  = size_t'(eq_n);
        bus.larger_size = size_t'(hi_n);
        bus.min_lower   = 8'(mnl);
        bus.max_lower   = 8'(mxl);
        bus.min_larger  = 8'(mng);
        bus.max_larger  = 8'(mxg);
        dp_count++;
        if (stall_at != 0 && dp_count == stall_at) dp_wait = -1;
        else dp_wait = int'($urandom_range(0, 3));
      end else if (dp_wait == 0) begin
        bus.fill_done = 1'b1;
        dp_wait = -1;
      end else if (dp_wait > 0) begin
        dp_wait--;
      end
    end
  end

  // Per-cycle scoreboard against the model's pass list and final answer.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.send_req) begin
        sends++;
        if (exp_piv.size() == 0) begin
          chk("unexpected_send_req", 1, 0);
        end else begin
          chk("pass_pivot", int'(bus.pivot), exp_piv.pop_front());
          chk("pass_buff_size", int'(bus.buff_size), exp_size.pop_front());
          chk("pass_part_sel", int'(bus.part_sel), exp_part.pop_front());
          chk("busy_in_clear", int'(bus.busy), 1);
          chk("sending_in_clear", int'(bus.sending), 0);
        end
      end
      if (bus.result_valid) begin
        chk("result", int'(bus.result), exp_res);
        chk("result_err", int'(bus.result_err), exp_err);
        chk("sending_in_done", int'(bus.sending), 1);
        chk("busy_in_done", int'(bus.busy), 1);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_pivot"}, int'(bus.pivot), 128);
    chk({tag, "_buff_size"}, int'(bus.buff_size), 0);
    chk({tag, "_send_req"}, int'(bus.send_req), 0);
    chk({tag, "_sending"}, int'(bus.sending), 0);
    chk({tag, "_part_sel"}, int'(bus.part_sel), 0);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_result_err"}, int'(bus.result_err), 0);
    chk({tag, "_result_valid"}, int'(bus.result_valid), 0);
  endtask

  task automatic start_txn(input int s, input int pos);
    int m_res, m_err, m_pass;
    cur_s = s;
    dp_count = 0;
    sends = 0;
    model_run(s, pos, m_res, m_err, m_pass);
    exp_err = m_err;
    exp_res = (s != 0 && m_err == 0) ? sorted_rank(s, pos) : m_res;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_buff_size = size_t'(s);
    bus.in_median_pos = size_t'(pos);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lit_res/lit_pass < 0 mean "no hand-computed value for this case".
  task automatic run_txn(input int s, input int pos, input int lit_res, input int lit_pass, input int hold);
    int cyc;
    int held;
    bit got;
    start_txn(s, pos);
    got = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (bus.result_valid) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("result_valid_timeout", 0, 1);
    end else begin
      held = int'(bus.result);
      if (lit_res >= 0) chk("literal_result", held, lit_res);
      if (lit_pass >= 0) chk("literal_passes", sends, lit_pass);
      for (int h = 0; h < hold; h++) begin
        bus.start = 1'b1;
        bus.in_buff_size = size_t'(3);
        bus.in_median_pos = size_t'(1);
        @(negedge clk);
        chk("hold_result_stable", int'(bus.result), held);
        chk("hold_busy", int'(bus.busy), 1);
        chk("hold_valid", int'(bus.result_valid), 1);
      end
      bus.start = 1'b0;
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      chk("after_ack_busy", int'(bus.busy), 0);
      chk("after_ack_valid", int'(bus.result_valid), 0);
      chk("after_ack_err", int'(bus.result_err), 0);
      chk("passes_all_seen", exp_piv.size(), 0);
      $display("txn S=%0d pos=%0d result=%0d err=%0d passes=%0d", s, pos, held, exp_err, sends);
    end
  endtask

  initial begin
    int s, pos, lo_v;
    bus.start = 1'b0;
    bus.in_buff_size = '0;
    bus.in_median_pos = '0;
    bus.result_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two-pass example: expected 50 after 2 clear pulses.
    win[0] = 8'd10; win[1] = 8'd200; win[2] = 8'd50; win[3] = 8'd50; win[4] = 8'd90;
    run_txn(5, 2, 50, 2, 0);

    // Nine identical pixels resolve in one pass.
    for (int i = 0; i < 9; i++) win[i] = 8'd77;
    run_txn(9, 4, 77, 1, 0);

    // Single pixel above the initial pivot.
    win[0] = 8'd255;
    run_txn(1, 0, 255, 1, 0);
    chk("single_part_sel", int'(bus.part_sel), 0);

    // Rank beyond the window clamps to the last element (the maximum).
    win[0] = 8'd30; win[1] = 8'd7; win[2] = 8'd99; win[3] = 8'd64;
    run_txn(4, 9, 99, 3, 0);

    // Empty window: error with no datapath passes.
    run_txn(0, 0, 0, 0, 0);

    // Consumer stalls for 5 cycles while start is pulsed.
    win[0] = 8'd10; win[1] = 8'd200; win[2] = 8'd50; win[3] = 8'd50; win[4] = 8'd90;
    run_txn(5, 2, 50, 2, 5);

    // Randomised windows, including duplicate-heavy ones.
    for (int t = 0; t < 40; t++) begin
      s = int'($urandom_range(0, 32));
      pos = int'($urandom_range(0, 40));
      lo_v = int'($urandom_range(0, 252));
      for (int i = 0; i < 32; i++) begin
        if (t % 3 == 0) win[i] = 8'(lo_v + int'($urandom_range(0, 3)));
        else win[i] = 8'($urandom_range(0, 255));
      end
      run_txn(s, pos, -1, -1, int'($urandom_range(0, 2)));
    end

    // Reset during the FILL of pass 2, then a clean run.
    win[0] = 8'd10; win[1] = 8'd200; win[2] = 8'd50; win[3] = 8'd50; win[4] = 8'd90;
    stall_at = 2;
    start_txn(5, 2);
    for (int c = 0; c < 200 && dp_count < 2; c++) @(negedge clk);
    chk("reached_pass2", dp_count, 2);
    repeat (2) @(negedge clk);
    chk("stalled_busy", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    exp_piv.delete(); exp_size.delete(); exp_part.delete();
    @(negedge clk);
    rst = 1'b0;
    stall_at = 0;
    @(negedge clk);
    run_txn(5, 2, 50, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/median_select_ctrl.md
Name: median_select_ctrl

Overview:
- Sequencer for the fill_buffers partition datapath; performs iterative quickselect on one window of 8-bit pixels.
- Per pass: sets pivot and buffer size, pulses send_req to clear the datapath statistics, then waits for fill_done.
- After each pass, reads the partition sizes and min/max values and either finishes or selects the partition upstream must replay next.
- Sits between the window/median-position source and fill_buffers; returns one median value per start.

Parameters:
BUFF_SIZE, 32, maximum pixels per window
BUFF_SIZE_BIT, $clog2(BUFF_SIZE)+1, width of size/position/count fields
INIT_PIVOT, 8'd128, pivot used for the first pass
MAX_PASS, 10, pass limit before an error abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request; accepted when busy=0
in_buff_size  in  BUFF_SIZE_BIT  window size, sampled on start
in_median_pos  in  BUFF_SIZE_BIT  0-based rank to select, sampled on start
busy  out  1  high from acceptance until result handshake
fill_done  in  1  from fill_buffers
lower_size, equal_size, larger_size  in  BUFF_SIZE_BIT each  partition counts
min_lower, max_lower, min_larger, max_larger  in  8 each  partition extrema
pivot  out  8  pivot to datapath, registered
buff_size  out  BUFF_SIZE_BIT  size for current pass, registered
send_req  out  1  one-cycle clear pulse to datapath
sending  out  1  holds datapath pixel count while deciding
part_sel  out  2  replay source for upstream: 00 all, 01 lower, 10 larger
result  out  8  selected value
result_err  out  1  set with result on abort
result_valid  out  1  result available
result_ready  in  1  consumer accepts

Behaviour:
- Reset values: state=IDLE, busy=0, pivot=INIT_PIVOT, buff_size=0, send_req=0, sending=0, part_sel=00, result=0, result_err=0, result_valid=0, internal k=0, pass=0.
- IDLE
  - On start: latch size S and k=min(in_median_pos, S-1).
  - S=0: go to DONE with result=0, result_err=1.
  - Otherwise: pivot=INIT_PIVOT, buff_size=S, part_sel=00, pass=0; go to CLEAR.
- CLEAR (1 cycle): send_req=1, sending=0; go to FILL.
- FILL: sending=0; wait for fill_done=1, then go to DECIDE. The partition inputs are stable from that cycle onward.
- DECIDE (1 cycle): sending=1 so the datapath count is not restarted; pass+=1. Let L=lower_size, E=equal_size.
  - k<L: target is in lower. If L=1 or min_lower==max_lower, result=min_lower and go to DONE. Otherwise buff_size=L, pivot=(min_lower+max_lower)>>1 (9-bit sum), part_sel=01, go to CLEAR.
  - k<L+E: result=pivot, go to DONE.
  - Otherwise: k=k-L-E, target is in larger. Same rule as lower using min_larger/max_larger, size=larger_size, part_sel=10.
  - If pass reaches MAX_PASS without resolving: result_err=1, result=pivot, go to DONE.
- Floor midpoint with min<max guarantees strict shrink: max>pivot, so larger is non-empty; min<=pivot, so lower+equal is non-empty.
- DONE: result_valid=1; sending stays 1 until the handshake.
  - On result_valid & result_ready: clear result_valid, result_err, busy; return to IDLE.
  - start is ignored while busy.
- fill_done arriving outside FILL is ignored.
- Arithmetic: size and rank comparisons are unsigned at BUFF_SIZE_BIT; L+E is computed one bit wider.
- Latency: 3 cycles per pass (CLEAR, ≥1 FILL, DECIDE) plus datapath fill time; result_valid appears the cycle after the final DECIDE.
- rst asserted mid-operation returns everything to reset values immediately; any partial pass is discarded.

Decomposition:
- Shared package median_pkg holds:
  - state encoding IDLE/CLEAR/FILL/DECIDE/DONE
  - part_sel codes PART_ALL/PART_LOWER/PART_LARGER
  - INIT_PIVOT default
- Single sub-module median_pivot_calc (combinational): takes k, sizes, extrema and current pivot; returns next action, next pivot, next size, next k and part_sel. The FSM stays in median_select_ctrl.

Test Plan:
- Window {10,200,50,50,90}, S=5, pos=2.
  - Pass 1 (pivot 128): L=4, E=0, larger=1.
  - Pass 2 (pivot 50, part_sel=01, buff_size=4): L=1, E=2.
  - Required: result=50, 2 send_req pulses, result_err=0.
- Nine pixels all 77, pos=4 -> pass 1 gives L=9, min=max=77 -> result=77 after exactly 1 pass, no second CLEAR.
- S=1, pixel 255, pos=0 -> larger_size=1 -> result=255, part_sel stays 00.
- S=4, pos=9 -> k clamped to 3 -> result equals the maximum pixel. Separately, S=0 -> result_err=1, result=0, no send_req.
- Hold result_ready=0 for 5 cycles after result_valid -> result stable, busy=1, start ignored. Then ready=1 -> returns to IDLE next cycle.
- Assert rst during FILL of pass 2 -> all outputs at reset values the same cycle. A new start afterwards completes correctly.
